debug_monitor: RTL and testbench

Parametrised debug display controller for the FPGA-board MIPS top level. It takes NCH debounced-button-navigable data channels and presents one NDIG-digit hex page of the selected channel, with an optional auto-scroll mode and a freeze snapshot. It also generates the CPU step enable, either single-step or free-run. It replaces the fixed 3-way selector plus button-as-clock arrangement, and sits between BTN_IN outputs, the CPU debug buses and the SEG7DEC instances.

---
 rtl/debug_monitor_pkg.sv | 33 +++
 rtl/debug_monitor_tick_gen.sv | 32 +++
 rtl/debug_monitor.sv | 161 ++++++++++++++++
 tb/tb_debug_monitor.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/debug_monitor_pkg.sv
// Shared sizing helpers and the nibble extractor for the debug display controller.
package debug_monitor_pkg;

  localparam int MAX_DATA_W = 256;
  localparam int MAX_IDX_W  = 8;

  typedef enum logic [1:0] {
    NAV_HOLD = 2'd0,
    NAV_NEXT = 2'd1,
    NAV_PREV = 2'd2
  } nav_e;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int pages_per_ch(input int data_w, input int ndig);
    return (data_w + 4 * ndig - 1) / (4 * ndig);
  endfunction

  // Bits at or above data_w read as zero so a partial last page shows leading 0s.
  function automatic logic [3:0] nibble_at(input logic [MAX_DATA_W-1:0] src,
                                           input int data_w,
                                           input int lsb);
    logic [3:0] nib;
    nib = '0;
    for (int i = 0; i < 4; i++) begin
      if (lsb + i < data_w) nib[i] = src[MAX_IDX_W'(lsb + i)];
    end
    return nib;
  endfunction

endpackage

// File: rtl/debug_monitor_tick_gen.sv
// Free-running divide-by-DIV counter with synchronous clear; tick is high on the last count.
module tick_gen
  import debug_monitor_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  output logic o_tick
);

  localparam int CW = clog2_min1(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          w_wrap;

  assign w_wrap = (r_cnt == LAST);
  assign o_tick = w_wrap && !i_clr;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr || w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/debug_monitor.sv
// Paged hex display of NCH debug channels with auto-scroll, freeze snapshot and CPU step control.
module debug_monitor
  import debug_monitor_pkg::*;
#(
  parameter int NCH        = 8,
  parameter int DATA_W     = 32,
  parameter int NDIG       = 4,
  parameter int SCROLL_DIV = 50_000_000,
  parameter int RUN_DIV    = 5_000_000,
  localparam int P         = pages_per_ch(DATA_W, NDIG),
  localparam int CW        = clog2_min1(NCH),
  localparam int PW        = clog2_min1(P)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_btn_next,
  input  logic                  i_btn_prev,
  input  logic                  i_btn_step,
  input  logic                  i_scroll_en,
  input  logic                  i_run_en,
  input  logic                  i_freeze,
  input  logic [NCH*DATA_W-1:0] i_ch_data,
  output logic                  o_cpu_ce,
  output logic [15:0]           o_step_cnt,
  output logic [NDIG*4-1:0]     o_digits,
  output logic [CW-1:0]         o_ch_sel,
  output logic [PW-1:0]         o_page,
  output logic [NCH-1:0]        o_led
);

  localparam logic [CW-1:0] CH_LAST   = CW'(NCH - 1);
  localparam logic [PW-1:0] PAGE_LAST = PW'(P - 1);

  logic [CW-1:0]           r_ch_sel;
  logic [PW-1:0]           r_page;
  logic [NDIG*4-1:0]       r_digits;
  logic [NCH*DATA_W-1:0]   r_snap;
  logic                    r_freeze_d;
  logic                    r_cpu_ce;
  logic [15:0]             r_step_cnt;

  logic                    w_scroll_tick;
  logic                    w_scroll_clr;
  logic                    w_run_tick;
  logic                    w_run_clr;
  nav_e                    w_nav;
  logic [CW-1:0]           w_ch_next;
  logic [PW-1:0]           w_page_next;
  logic                    w_freeze_rise;
  logic [NCH*DATA_W-1:0]   w_src;
  logic [DATA_W-1:0]       w_ch_word [NCH];
  logic [DATA_W-1:0]       w_word;
  logic [MAX_DATA_W-1:0]   w_word_ext;
  logic [NDIG*4-1:0]       w_digits_next;

  // A manual press restarts the scroll period, which also drops a coincident tick.
  assign w_scroll_clr = !i_scroll_en || i_btn_next || i_btn_prev;
  assign w_run_clr    = !i_run_en;

  tick_gen #(.DIV(SCROLL_DIV)) u_scroll_tick (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_clr  (w_scroll_clr),
    .o_tick (w_scroll_tick)
  );

  tick_gen #(.DIV(RUN_DIV)) u_run_tick (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_clr  (w_run_clr),
    .o_tick (w_run_tick)
  );

  always_comb begin
    w_nav = NAV_HOLD;
    if (i_btn_next && !i_btn_prev) begin
      w_nav = NAV_NEXT;
    end else if (i_btn_prev && !i_btn_next) begin
      w_nav = NAV_PREV;
    end else if (!i_btn_next && !i_btn_prev && w_scroll_tick) begin
      w_nav = NAV_NEXT;
    end
  end

  always_comb begin
    w_ch_next   = r_ch_sel;
    w_page_next = r_page;
    case (w_nav)
      NAV_NEXT: begin
        if (r_page == PAGE_LAST) begin
          w_page_next = '0;
          w_ch_next   = (r_ch_sel == CH_LAST) ? '0 : r_ch_sel + 1'b1;
        end else begin
          w_page_next = r_page + 1'b1;
        end
      end
      NAV_PREV: begin
        if (r_page == '0) begin
          w_page_next = PAGE_LAST;
          w_ch_next   = (r_ch_sel == '0) ? CH_LAST : r_ch_sel - 1'b1;
        end else begin
          w_page_next = r_page - 1'b1;
        end
      end
      default: ;
    endcase
  end

  // On the capture cycle the snapshot is not loaded yet, but live data equals what is captured.
  assign w_freeze_rise = i_freeze && !r_freeze_d;
  assign w_src         = (i_freeze && !w_freeze_rise) ? r_snap : i_ch_data;

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      assign w_ch_word[gi] = w_src[gi*DATA_W +: DATA_W];
    end
  endgenerate

  assign w_word = w_ch_word[r_ch_sel];

  always_comb begin
    w_word_ext             = '0;
    w_word_ext[DATA_W-1:0] = w_word;
  end

  generate
    for (gi = 0; gi < NDIG; gi++) begin : g_dig
      assign w_digits_next[gi*4 +: 4] =
        nibble_at(w_word_ext, DATA_W, (int'(r_page) * NDIG + gi) * 4);
    end
  endgenerate

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ch_sel   <= '0;
      r_page     <= '0;
      r_digits   <= '0;
      r_snap     <= '0;
      r_freeze_d <= 1'b0;
      r_cpu_ce   <= 1'b0;
      r_step_cnt <= '0;
    end else begin
      r_ch_sel   <= w_ch_next;
      r_page     <= w_page_next;
      r_digits   <= w_digits_next;
      r_freeze_d <= i_freeze;
      if (w_freeze_rise) r_snap <= i_ch_data;
      r_cpu_ce   <= i_run_en ? w_run_tick : i_btn_step;
      if (r_cpu_ce) r_step_cnt <= r_step_cnt + 16'd1;
    end
  end

  assign o_cpu_ce   = r_cpu_ce;
  assign o_step_cnt = r_step_cnt;
  assign o_digits   = r_digits;
  assign o_ch_sel   = r_ch_sel;
  assign o_page     = r_page;
  assign o_led      = {{(NCH-1){1'b0}}, 1'b1} << r_ch_sel;

endmodule

// File: tb/tb_debug_monitor.sv
// Directed bench for debug_monitor: main 8x32 instance plus a small 2x8 instance for zero fill and counter wrap.
module tb_debug_monitor;

  logic         clk;
  logic         rst;
  logic         btn_next, btn_prev, btn_step, scroll_en, run_en, freeze;
  logic [255:0] ch_data;
  logic         cpu_ce;
  logic [15:0]  step_cnt;
  logic [15:0]  digits;
  logic [2:0]   ch_sel;
  logic [0:0]   page;
  logic [7:0]   led;

  logic         rst2, btn_next2, btn_prev2, btn_step2, scroll_en2, run_en2, freeze2;
  logic [15:0]  ch_data2;
  logic         cpu_ce2;
  logic [15:0]  step_cnt2;
  logic [11:0]  digits2;
  logic [0:0]   ch_sel2;
  logic [0:0]   page2;
  logic [1:0]   led2;

  int errors = 0;
  int checks = 0;

  debug_monitor #(.NCH(8), .DATA_W(32), .NDIG(4), .SCROLL_DIV(4), .RUN_DIV(5)) dut (
    .i_clk(clk), .i_rst(rst), .i_btn_next(btn_next), .i_btn_prev(btn_prev),
    .i_btn_step(btn_step), .i_scroll_en(scroll_en), .i_run_en(run_en), .i_freeze(freeze),
    .i_ch_data(ch_data), .o_cpu_ce(cpu_ce), .o_step_cnt(step_cnt), .o_digits(digits),
    .o_ch_sel(ch_sel), .o_page(page), .o_led(led)
  );

  debug_monitor #(.NCH(2), .DATA_W(8), .NDIG(3), .SCROLL_DIV(4), .RUN_DIV(1)) dut2 (
    .i_clk(clk), .i_rst(rst2), .i_btn_next(btn_next2), .i_btn_prev(btn_prev2),
    .i_btn_step(btn_step2), .i_scroll_en(scroll_en2), .i_run_en(run_en2), .i_freeze(freeze2),
    .i_ch_data(ch_data2), .o_cpu_ce(cpu_ce2), .o_step_cnt(step_cnt2), .o_digits(digits2),
    .o_ch_sel(ch_sel2), .o_page(page2), .o_led(led2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Pulse helpers: called at a negedge, return at the next negedge with the move applied.
  task automatic pulse_next();
    btn_next = 1'b1;
    @(negedge clk);
    btn_next = 1'b0;
  endtask

  task automatic pulse_prev();
    btn_prev = 1'b1;
    @(negedge clk);
    btn_prev = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    checks++; if (ch_sel !== 3'd0) begin errors++; $display("FAIL reset_ch_sel got %0d expected 0", ch_sel); end
    checks++; if (page !== 1'b0) begin errors++; $display("FAIL reset_page got %0d expected 0", page); end
    checks++; if (digits !== 16'h0000) begin errors++; $display("FAIL reset_digits got %h expected 0000", digits); end
    checks++; if (led !== 8'h01) begin errors++; $display("FAIL reset_led got %h expected 01", led); end
    checks++; if (cpu_ce !== 1'b0 || step_cnt !== 16'd0) begin errors++; $display("FAIL reset_step got ce=%b cnt=%h expected 0/0000", cpu_ce, step_cnt); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (digits !== 16'hABCD) begin errors++; $display("FAIL first_page got %h expected abcd", digits); end
    $display("test_reset done");
  endtask

  task automatic test_next();
    pulse_next();
    checks++; if (page !== 1'b1 || ch_sel !== 3'd0) begin errors++; $display("FAIL next_pos got (%0d,%0d) expected (0,1)", ch_sel, page); end
    checks++; if (digits !== 16'hABCD) begin errors++; $display("FAIL next_digits_t1 got %h expected abcd", digits); end
    @(negedge clk);
    checks++; if (digits !== 16'h1234) begin errors++; $display("FAIL next_digits_t2 got %h expected 1234", digits); end
    $display("test_next done");
  endtask

  task automatic test_wrap();
    pulse_prev();
    checks++; if (page !== 1'b0 || ch_sel !== 3'd0) begin errors++; $display("FAIL prev_pos got (%0d,%0d) expected (0,0)", ch_sel, page); end
    pulse_prev();
    checks++; if (ch_sel !== 3'd7 || page !== 1'b1) begin errors++; $display("FAIL prev_wrap got (%0d,%0d) expected (7,1)", ch_sel, page); end
    checks++; if (led !== 8'h80) begin errors++; $display("FAIL prev_wrap_led got %h expected 80", led); end
    @(negedge clk);
    checks++; if (digits !== 16'hC0DE) begin errors++; $display("FAIL ch7_page1 got %h expected c0de", digits); end
    for (int i = 0; i < 16; i++) pulse_next();
    checks++; if (ch_sel !== 3'd7 || page !== 1'b1) begin errors++; $display("FAIL next16 got (%0d,%0d) expected (7,1)", ch_sel, page); end
    btn_next = 1'b1;
    btn_prev = 1'b1;
    @(negedge clk);
    btn_next = 1'b0;
    btn_prev = 1'b0;
    checks++; if (ch_sel !== 3'd7 || page !== 1'b1) begin errors++; $display("FAIL both_pressed got (%0d,%0d) expected (7,1)", ch_sel, page); end
    pulse_next();
    checks++; if (ch_sel !== 3'd0 || page !== 1'b0 || led !== 8'h01) begin errors++; $display("FAIL next_wrap got (%0d,%0d) led %h expected (0,0) 01", ch_sel, page, led); end
    $display("test_wrap done");
  endtask

  task automatic test_scroll();
    scroll_en = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      checks++;
      if (ch_sel !== 3'd0 || page !== ((i == 4) ? 1'b1 : 1'b0)) begin
        errors++; $display("FAIL scroll_cycle%0d got (%0d,%0d) expected (0,%0d)", i, ch_sel, page, (i == 4));
      end
    end
    @(negedge clk);
    btn_next = 1'b1;
    @(negedge clk);
    btn_next = 1'b0;
    checks++; if (ch_sel !== 3'd1 || page !== 1'b0) begin errors++; $display("FAIL scroll_press got (%0d,%0d) expected (1,0)", ch_sel, page); end
    for (int i = 7; i <= 10; i++) begin
      @(negedge clk);
      checks++;
      if (ch_sel !== 3'd1 || page !== ((i == 10) ? 1'b1 : 1'b0)) begin
        errors++; $display("FAIL scroll_restart%0d got (%0d,%0d) expected (1,%0d)", i, ch_sel, page, (i == 10));
      end
    end
    scroll_en = 1'b0;
    for (int i = 0; i < 5; i++) @(negedge clk);
    checks++; if (ch_sel !== 3'd1 || page !== 1'b1) begin errors++; $display("FAIL scroll_off got (%0d,%0d) expected (1,1)", ch_sel, page); end
    for (int i = 0; i < 3; i++) pulse_prev();
    $display("test_scroll done");
  endtask

  task automatic test_freeze();
    ch_data[31:0] = 32'h11112222;
    @(negedge clk);
    checks++; if (digits !== 16'h2222) begin errors++; $display("FAIL live_update got %h expected 2222", digits); end
    freeze = 1'b1;
    @(negedge clk);
    ch_data[31:0] = 32'hFFFFFFFF;
    @(negedge clk);
    @(negedge clk);
    checks++; if (digits !== 16'h2222) begin errors++; $display("FAIL frozen got %h expected 2222", digits); end
    pulse_next();
    @(negedge clk);
    checks++; if (digits !== 16'h1111) begin errors++; $display("FAIL frozen_next got %h expected 1111", digits); end
    pulse_prev();
    freeze = 1'b0;
    @(negedge clk);
    checks++; if (digits !== 16'hFFFF) begin errors++; $display("FAIL unfrozen got %h expected ffff", digits); end
    $display("test_freeze done");
  endtask

  task automatic test_step();
    int ce_seen;
    logic exp_ce;
    ce_seen = 0;
    for (int i = 0; i < 12; i++) begin
      exp_ce = (i % 3 == 0) && (i < 9);
      btn_step = exp_ce;
      @(negedge clk);
      if (cpu_ce === 1'b1) ce_seen++;
      checks++; if (cpu_ce !== exp_ce) begin errors++; $display("FAIL step_ce%0d got %b expected %b", i, cpu_ce, exp_ce); end
    end
    btn_step = 1'b0;
    checks++; if (ce_seen != 3) begin errors++; $display("FAIL step_pulses got %0d expected 3", ce_seen); end
    checks++; if (step_cnt !== 16'd3) begin errors++; $display("FAIL step_cnt got %0d expected 3", step_cnt); end
    run_en = 1'b1;
    btn_step = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      checks++; if (cpu_ce !== (i % 5 == 0)) begin errors++; $display("FAIL run_ce%0d got %b expected %b", i, cpu_ce, (i % 5 == 0)); end
    end
    checks++; if (step_cnt !== 16'd5) begin errors++; $display("FAIL run_cnt got %0d expected 5", step_cnt); end
    run_en = 1'b0;
    btn_step = 1'b0;
    @(negedge clk);
    checks++; if (cpu_ce !== 1'b0 || step_cnt !== 16'd6) begin errors++; $display("FAIL run_stop got ce=%b cnt=%0d expected 0/6", cpu_ce, step_cnt); end
    $display("test_step done");
  endtask

  task automatic test_async_reset();
    freeze = 1'b1;
    run_en = 1'b1;
    pulse_next();
    for (int i = 0; i < 5; i++) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++; if (ch_sel !== 3'd0 || page !== 1'b0 || led !== 8'h01) begin errors++; $display("FAIL async_pos got (%0d,%0d) led %h expected (0,0) 01", ch_sel, page, led); end
    checks++; if (digits !== 16'h0000) begin errors++; $display("FAIL async_digits got %h expected 0000", digits); end
    checks++; if (step_cnt !== 16'd0 || cpu_ce !== 1'b0) begin errors++; $display("FAIL async_step got ce=%b cnt=%0d expected 0/0", cpu_ce, step_cnt); end
    freeze = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      checks++; if (cpu_ce !== (i == 5)) begin errors++; $display("FAIL post_reset_run%0d got %b expected %b", i, cpu_ce, (i == 5)); end
    end
    run_en = 1'b0;
    @(negedge clk);
    $display("test_async_reset done");
  endtask

  task automatic test_small_cfg();
    rst2 = 1'b0;
    @(negedge clk);
    checks++; if (digits2 !== 12'h0A5) begin errors++; $display("FAIL small_zero_fill got %h expected 0a5", digits2); end
    btn_next2 = 1'b1;
    @(negedge clk);
    btn_next2 = 1'b0;
    checks++; if (ch_sel2 !== 1'b1 || page2 !== 1'b0 || led2 !== 2'b10) begin errors++; $display("FAIL small_next got (%0d,%0d) led %b expected (1,0) 10", ch_sel2, page2, led2); end
    @(negedge clk);
    checks++; if (digits2 !== 12'h03C) begin errors++; $display("FAIL small_ch1 got %h expected 03c", digits2); end
    run_en2 = 1'b1;
    for (int i = 1; i <= 65537; i++) begin
      @(negedge clk);
      if (i == 65536) begin
        checks++; if (step_cnt2 !== 16'hFFFF) begin errors++; $display("FAIL cnt_max got %h expected ffff", step_cnt2); end
      end
      if (i == 65537) begin
        checks++; if (step_cnt2 !== 16'h0000) begin errors++; $display("FAIL cnt_wrap got %h expected 0000", step_cnt2); end
      end
    end
    run_en2 = 1'b0;
    $display("test_small_cfg done");
  endtask

  initial begin
    rst = 1'b1;
    btn_next = 1'b0; btn_prev = 1'b0; btn_step = 1'b0;
    scroll_en = 1'b0; run_en = 1'b0; freeze = 1'b0;
    ch_data = '0;
    ch_data[31:0] = 32'h1234ABCD;
    for (int k = 1; k < 8; k++) ch_data[k*32 +: 32] = 32'hC0DE0000 | k;
    rst2 = 1'b1;
    btn_next2 = 1'b0; btn_prev2 = 1'b0; btn_step2 = 1'b0;
    scroll_en2 = 1'b0; run_en2 = 1'b0; freeze2 = 1'b0;
    ch_data2 = 16'h3CA5;

    test_reset();
    test_next();
    test_wrap();
    test_scroll();
    test_freeze();
    test_step();
    test_async_reset();
    test_small_cfg();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
